// File: rtl/key_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : key_cmd_encoder
// Description : Debounces three active-low keys, auto-repeats LEFT/RIGHT and
//               encodes them into a one-entry valid/ready command stream.
// Revision    : 1.0
// ============================================================================
module key_cmd_encoder #(
   parameter int DEB_CYC = 1_000_000,
   parameter int RPT_DLY = 25_000_000,
   parameter int RPT_PER = 5_000_000,
   parameter bit RPT_EN  = 1'b1,
   parameter int CNT_W   = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key0,
   input  logic       key1,
   input  logic       key2,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [1:0] cmd_code,
   output logic       cmd_overflow,
   output logic [2:0] key_level
);

   localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(RPT_DLY - 1);
   localparam logic [CNT_W-1:0] c_PER_LAST = CNT_W'(RPT_PER - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] c_CODE_STOP  = 2'b01;
   localparam logic [1:0] c_CODE_LEFT  = 2'b10;
   localparam logic [1:0] c_CODE_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RPT  = 2'd2
   } state_t;

   logic [2:0]       r_sync1;
   logic [2:0]       r_sync2;
   logic [2:0]       w_stable;
   logic [2:0]       r_stable_d;
   logic [2:0]       w_press;
   logic             w_press_any;
   logic [1:0]       w_press_code;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_rcnt;
   logic [CNT_W-1:0] w_rcnt_nxt;
   logic             r_rkey;
   logic             w_rkey_nxt;
   logic             w_rpt;
   logic             w_cap_rel;

   logic             w_ev;
   logic [1:0]       w_ev_code;
   logic             r_valid;
   logic [1:0]       r_code;
   logic             r_ovf;

   // Keys idle high, so the synchroniser resets to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
      end else begin
         r_sync1 <= {key2, key1, key0};
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b1;
         end else if (r_sync2[gi] == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == c_DEB_LAST) begin
            r_stable <= r_sync2[gi];
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
      end

      assign w_stable[gi] = r_stable;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable_d <= 3'b111;
      end else begin
         r_stable_d <= w_stable;
      end
   end

   assign w_press     = r_stable_d & ~w_stable;
   assign w_press_any = |w_press;

   always_comb begin
      w_press_code = c_CODE_RIGHT;
      if (w_press[0]) begin
         w_press_code = c_CODE_STOP;
      end else if (w_press[1]) begin
         w_press_code = c_CODE_LEFT;
      end
   end

   assign w_cap_rel = r_rkey ? w_stable[2] : w_stable[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rcnt  <= '0;
         r_rkey  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_rcnt  <= w_rcnt_nxt;
         r_rkey  <= w_rkey_nxt;
      end
   end

   // A fresh press always restarts the repeat timer; STOP cancels repeating.
   always_comb begin
      w_state_nxt = r_state;
      w_rcnt_nxt  = r_rcnt;
      w_rkey_nxt  = r_rkey;
      w_rpt       = 1'b0;
      if (w_press_any) begin
         w_rcnt_nxt = '0;
         if (w_press[0] || !RPT_EN) begin
            w_state_nxt = ST_IDLE;
         end else begin
            w_state_nxt = ST_HOLD;
            w_rkey_nxt  = ~w_press[1];
         end
      end else begin
         case (r_state)
            ST_HOLD, ST_RPT: begin
               if (w_cap_rel) begin
                  w_state_nxt = ST_IDLE;
                  w_rcnt_nxt  = '0;
               end else if (r_rcnt == ((r_state == ST_HOLD) ? c_DLY_LAST : c_PER_LAST)) begin
                  w_rpt       = 1'b1;
                  w_rcnt_nxt  = '0;
                  w_state_nxt = ST_RPT;
               end else begin
                  w_rcnt_nxt = r_rcnt + c_CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_rcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign w_ev      = w_press_any | w_rpt;
   assign w_ev_code = w_press_any ? w_press_code : (r_rkey ? c_CODE_RIGHT : c_CODE_LEFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_code  <= 2'b00;
         r_ovf   <= 1'b0;
      end else begin
         r_ovf <= 1'b0;
         if (w_ev) begin
            if (!r_valid || cmd_ready) begin
               r_valid <= 1'b1;
               r_code  <= w_ev_code;
            end else begin
               r_ovf <= 1'b1;
            end
         end else if (r_valid && cmd_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign cmd_valid    = r_valid;
   assign cmd_code     = r_code;
   assign cmd_overflow = r_ovf;
   assign key_level    = ~w_stable;

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_cmd_encoder
// Description : Directed bench with a cycle-stamped scoreboard of commands.
// Revision    : 1.0
// ============================================================================
module tb_key_cmd_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key0, key1, key2;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic       cmd_overflow;
   logic [2:0] key_level;

   typedef struct {
      logic [1:0] code;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   ovf_cnt = 0;
   int   k;

   key_cmd_encoder #(
      .DEB_CYC(4),
      .RPT_DLY(20),
      .RPT_PER(8),
      .RPT_EN (1'b1),
      .CNT_W  (26)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key0        (key0),
      .key1        (key1),
      .key2        (key2),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_overflow(cmd_overflow),
      .key_level   (key_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every handshake must match the next expected command and its load edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_overflow) ovf_cnt++;
         if (cmd_valid && cmd_ready) begin
            if (q.size() == 0) begin
               chk("cmd_valid_unexpected", {31'd0, cmd_valid}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("cmd_code", {30'd0, cmd_code}, {30'd0, e.code});
               chk("cmd_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; key0 = 1'b1; key1 = 1'b1; key2 = 1'b1; cmd_ready = 1'b1;
      step(3);
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_code", {30'd0, cmd_code}, 32'd0);
      chk("rst_ovf", {31'd0, cmd_overflow}, 32'd0);
      chk("rst_level", {29'd0, key_level}, 32'd0);
      rst_n = 1'b1;
      step(3);

      // Short glitch must be filtered.
      key1 = 1'b0;
      step(3);
      key1 = 1'b1;
      step(2);
      chk("glitch_level_a", {29'd0, key_level}, 32'd0);
      step(8);
      chk("glitch_level_b", {29'd0, key_level}, 32'd0);

      // Single LEFT press latency.
      k = cyc;
      key1 = 1'b0;
      step(5);
      chk("left_level_early", {29'd0, key_level}, 32'd0);
      step(1);
      chk("left_level", {29'd0, key_level}, 32'b010);
      q.push_back('{2'b10, k + 7});
      step(4);
      key1 = 1'b1;
      step(20);
      chk("left_release_level", {29'd0, key_level}, 32'd0);

      // RIGHT held: press plus three repeats.
      k = cyc;
      key2 = 1'b0;
      q.push_back('{2'b11, k + 7});
      q.push_back('{2'b11, k + 27});
      q.push_back('{2'b11, k + 35});
      q.push_back('{2'b11, k + 43});
      step(40);
      key2 = 1'b1;
      step(20);
      chk("repeat_queue_empty", q.size(), 32'd0);

      // STOP and RIGHT together: STOP wins, no repeats.
      k = cyc;
      key0 = 1'b0; key2 = 1'b0;
      q.push_back('{2'b01, k + 7});
      step(40);
      key0 = 1'b1; key2 = 1'b1;
      step(15);
      chk("stop_queue_empty", q.size(), 32'd0);

      // Backpressure and overflow.
      k = cyc;
      cmd_ready = 1'b0;
      key1 = 1'b0;
      step(7);
      chk("bp_valid", {31'd0, cmd_valid}, 32'd1);
      chk("bp_code", {30'd0, cmd_code}, 32'b10);
      step(3);
      key2 = 1'b0;
      step(6);
      chk("ovf_before", {31'd0, cmd_overflow}, 32'd0);
      step(1);
      chk("ovf_pulse", {31'd0, cmd_overflow}, 32'd1);
      chk("ovf_code_held", {30'd0, cmd_code}, 32'b10);
      step(1);
      chk("ovf_after", {31'd0, cmd_overflow}, 32'd0);
      chk("ovf_valid_held", {31'd0, cmd_valid}, 32'd1);
      key1 = 1'b1; key2 = 1'b1;
      step(2);
      cmd_ready = 1'b1;
      q.push_back('{2'b10, k + 20});
      step(1);
      chk("bp_drain_valid", {31'd0, cmd_valid}, 32'd0);
      step(15);

      // Reset in HOLD with a pending command; key held through reset.
      k = cyc;
      cmd_ready = 1'b0;
      key1 = 1'b0;
      step(10);
      chk("pre_rst_valid", {31'd0, cmd_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("mid_rst_code", {30'd0, cmd_code}, 32'd0);
      chk("mid_rst_level", {29'd0, key_level}, 32'd0);
      chk("mid_rst_ovf", {31'd0, cmd_overflow}, 32'd0);
      step(2);
      rst_n = 1'b1;
      cmd_ready = 1'b1;
      q.push_back('{2'b10, k + 19});
      step(10);
      key1 = 1'b1;
      step(20);

      chk("final_queue_empty", q.size(), 32'd0);
      chk("overflow_count", ovf_cnt, 32'd1);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
